rd_scoreboard_ctrl: RTL and testbench

Issue controller for the RV32 pipeline's decode stage.
- Tracks outstanding long-latency register writes (loads, multi-cycle mul/div) in per-register pending counters.
- Stalls decode on RAW hazards, WAW saturation or a full scoreboard.
- Drives operand forwarding selects from the EX/MEM and MEM/WB destination-register buses.
- Sequences fence-style drain requests, releasing them only when all outstanding writes have retired.

---
 rtl/sb_pkg.sv | 36 +++
 rtl/rd_pending_counter.sv | 42 ++++
 rtl/rd_scoreboard_ctrl.sv | 144 ++++++++++++++
 tb/tb_rd_scoreboard_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types for the decode-stage read scoreboard: forwarding selects,
// drain FSM states and the register index width.
package sb_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,
    FWD_MEM_WB = 2'd1,
    FWD_EX_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } sb_state_e;

  // Youngest producer wins; x0 is hardwired zero and never forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_IDX_W-1:0] rs,
    input logic [REG_IDX_W-1:0] ex_mem_rd,
    input logic                 ex_mem_we,
    input logic [REG_IDX_W-1:0] mem_wb_rd,
    input logic                 mem_wb_we
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (ex_mem_we && (ex_mem_rd == rs))      sel = FWD_EX_MEM;
      else if (mem_wb_we && (mem_wb_rd == rs)) sel = FWD_MEM_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rd_pending_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module rd_pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             is_zero,
  output logic             is_max,
  output logic             underflow
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_dec_ok;
  logic             w_inc_ok;

  assign is_zero   = (r_cnt == '0);
  assign is_max    = (r_cnt == '1);
  assign underflow = dec & is_zero;
  assign cnt       = r_cnt;

  // A retire on an empty counter is dropped; a same-cycle valid retire makes
  // room for an increment even at saturation, so the pair nets to no change.
  assign w_dec_ok = dec & ~is_zero;
  assign w_inc_ok = inc & (~is_max | w_dec_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_inc_ok && !w_dec_ok) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dec_ok && !w_inc_ok) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/rd_scoreboard_ctrl.sv
// Decode-stage issue controller: pending-write scoreboard, RAW/WAW stalls,
// operand forwarding selects and fence-style drain sequencing.
module rd_scoreboard_ctrl
  import sb_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int CNT_W           = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 id_valid,
  input  logic                                 ex_ready,
  input  logic [REG_IDX_W-1:0]                 id_rs1,
  input  logic [REG_IDX_W-1:0]                 id_rs2,
  input  logic                                 id_rs1_used,
  input  logic                                 id_rs2_used,
  input  logic [REG_IDX_W-1:0]                 id_rd,
  input  logic                                 id_rd_we,
  input  logic                                 id_long_lat,
  input  logic [REG_IDX_W-1:0]                 ex_mem_rd,
  input  logic                                 ex_mem_reg_write,
  input  logic [REG_IDX_W-1:0]                 mem_wb_rd,
  input  logic                                 mem_wb_reg_write,
  input  logic                                 wb_valid,
  input  logic [REG_IDX_W-1:0]                 wb_rd,
  input  logic                                 flush,
  input  logic                                 drain_req,
  output logic                                 stall_id,
  output logic                                 issue,
  output fwd_sel_e                             fwd_a_sel,
  output fwd_sel_e                             fwd_b_sel,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 drain_done,
  output logic                                 sb_err
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_is_zero;
  logic [NUM_REGS-1:0] w_is_max;
  logic [NUM_REGS-1:0] w_underflow;

  logic                w_inc;
  logic                w_dec;
  logic                w_inc_ok;
  logic                w_dec_ok;

  logic [OUT_W-1:0]    r_outstanding;
  logic                r_sb_err;
  sb_state_e           r_state;
  sb_state_e           w_state_nxt;

  assign w_cnt[0]       = '0;
  assign w_is_zero[0]   = 1'b1;
  assign w_is_max[0]    = 1'b0;
  assign w_underflow[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    rd_pending_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_inc & (id_rd == REG_IDX_W'(g))),
      .dec       (w_dec & (wb_rd == REG_IDX_W'(g))),
      .clr       (flush),
      .cnt       (w_cnt[g]),
      .is_zero   (w_is_zero[g]),
      .is_max    (w_is_max[g]),
      .underflow (w_underflow[g])
    );
  end

  always_comb begin
    stall_id = 1'b0;
    if (!rst && id_valid) begin
      stall_id = (id_rs1_used && (id_rs1 != '0) && (w_cnt[id_rs1] != '0))
              || (id_rs2_used && (id_rs2 != '0) && (w_cnt[id_rs2] != '0))
              || (id_rd_we && id_long_lat && w_is_max[id_rd])
              || (id_long_lat && (r_outstanding == OUT_W'(MAX_OUTSTANDING)))
              || (r_state != RUN);
    end
  end

  assign issue = id_valid & ex_ready & ~stall_id;

  assign w_inc    = issue & id_rd_we & id_long_lat & (id_rd != '0);
  assign w_dec    = wb_valid & (wb_rd != '0);
  assign w_dec_ok = w_dec & ~w_is_zero[wb_rd];
  // Mirrors the per-register accept rule so the total tracks the counter sum.
  assign w_inc_ok = w_inc & (~w_is_max[id_rd] | (w_dec_ok & (wb_rd == id_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else if (flush) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= r_outstanding + OUT_W'(w_inc_ok) - OUT_W'(w_dec_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_err <= 1'b0;
    end else if (!flush && (|w_underflow)) begin
      r_sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    drain_done  = 1'b0;
    unique case (r_state)
      RUN:     if (drain_req) w_state_nxt = DRAIN;
      DRAIN:   if (r_outstanding == '0) w_state_nxt = DONE;
      DONE: begin
        drain_done  = 1'b1;
        w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
    if (flush) w_state_nxt = RUN;
  end

  assign fwd_a_sel = rst ? FWD_RF
                   : fwd_select(id_rs1, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
  assign fwd_b_sel = rst ? FWD_RF
                   : fwd_select(id_rs2, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);

  assign outstanding = r_outstanding;
  assign sb_err      = r_sb_err;

endmodule

// File: tb/tb_rd_scoreboard_ctrl.sv
// Self-checking bench for rd_scoreboard_ctrl: directed scenarios plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_rd_scoreboard_ctrl;

  localparam int NREG = 32;
  localparam int CMAX = 3;
  localparam int MAXO = 8;

  logic       clk;
  logic       rst;
  logic       id_valid, ex_ready;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_rd_we, id_long_lat;
  logic [4:0] ex_mem_rd, mem_wb_rd, wb_rd;
  logic       ex_mem_reg_write, mem_wb_reg_write, wb_valid;
  logic       flush, drain_req;

  logic       stall_id, issue, drain_done, sb_err;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [3:0] outstanding;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending writes per register, drain mode (0 run, 1 draining,
  // 2 completion cycle) and sticky error.
  int m_cnt [NREG];
  int m_mode;
  bit m_err;

  rd_scoreboard_ctrl #(
    .NUM_REGS        (32),
    .CNT_W           (2),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .ex_ready         (ex_ready),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rs1_used      (id_rs1_used),
    .id_rs2_used      (id_rs2_used),
    .id_rd            (id_rd),
    .id_rd_we         (id_rd_we),
    .id_long_lat      (id_long_lat),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .flush            (flush),
    .drain_req        (drain_req),
    .stall_id         (stall_id),
    .issue            (issue),
    .fwd_a_sel        (fwd_a_sel),
    .fwd_b_sel        (fwd_b_sel),
    .outstanding      (outstanding),
    .drain_done       (drain_done),
    .sb_err           (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < NREG; i++) s += m_cnt[i];
    return s;
  endfunction

  function automatic bit exp_stall();
    if (rst || !id_valid) return 1'b0;
    return (id_rs1_used && id_rs1 != 0 && m_cnt[id_rs1] != 0)
        || (id_rs2_used && id_rs2 != 0 && m_cnt[id_rs2] != 0)
        || (id_rd_we && id_long_lat && m_cnt[id_rd] == CMAX)
        || (id_long_lat && model_sum() == MAXO)
        || (m_mode != 0);
  endfunction

  function automatic bit exp_issue();
    return id_valid && ex_ready && !exp_stall();
  endfunction

  function automatic int exp_fwd(input logic [4:0] rs);
    if (rst || rs == 0) return 0;
    if (ex_mem_reg_write && ex_mem_rd == rs) return 2;
    if (mem_wb_reg_write && mem_wb_rd == rs) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    int s;
    bit iss;
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
      m_mode = 0;
      m_err  = 1'b0;
    end else begin
      s   = model_sum();
      iss = exp_issue();
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        m_mode = 0;
      end else begin
        case (m_mode)
          0: if (drain_req) m_mode = 1;
          1: if (s == 0) m_mode = 2;
          default: m_mode = 0;
        endcase
        if (wb_valid && wb_rd != 0) begin
          if (m_cnt[wb_rd] == 0) m_err = 1'b1;
          else m_cnt[wb_rd]--;
        end
        if (iss && id_rd_we && id_long_lat && id_rd != 0 && m_cnt[id_rd] < CMAX)
          m_cnt[id_rd]++;
      end
    end
  end

  always @(negedge clk) begin
    chk("stall_id",    int'(stall_id),    int'(exp_stall()));
    chk("issue",       int'(issue),       int'(exp_issue()));
    chk("fwd_a_sel",   int'(fwd_a_sel),   exp_fwd(id_rs1));
    chk("fwd_b_sel",   int'(fwd_b_sel),   exp_fwd(id_rs2));
    chk("outstanding", int'(outstanding), model_sum());
    chk("drain_done",  int'(drain_done),  int'(m_mode == 2 && !rst));
    chk("sb_err",      int'(sb_err),      int'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; ex_ready = 1; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0;
    id_rs2_used = 0; id_rd = 0; id_rd_we = 0; id_long_lat = 0;
    ex_mem_rd = 0; ex_mem_reg_write = 0; mem_wb_rd = 0; mem_wb_reg_write = 0;
    wb_valid = 0; wb_rd = 0; flush = 0; drain_req = 0;
  endtask

  task automatic long_op(input int rd);
    id_valid = 1; id_rd = 5'(rd); id_rd_we = 1; id_long_lat = 1;
    id_rs1_used = 0; id_rs2_used = 0;
  endtask

  task automatic retire(input int rd);
    wb_valid = 1; wb_rd = 5'(rd);
  endtask

  initial begin
    int pulses;
    int cand [$];
    rst = 1'b1;
    idle();
    repeat (3) step();
    mid();
    chk("reset_outstanding", int'(outstanding), 0);
    chk("reset_stall", int'(stall_id), 0);
    step();
    rst = 1'b0;
    step();

    // RAW on a load destination, released the cycle after its retire.
    long_op(5);
    mid(); chk("load_x5_issue", int'(issue), 1);
    step();
    idle(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    mid(); chk("raw_x5_stall", int'(stall_id), 1);
    chk("raw_x5_outstanding", int'(outstanding), 1);
    step();
    retire(5);
    mid(); chk("raw_x5_no_bypass", int'(stall_id), 1);
    step();
    wb_valid = 0;
    mid(); chk("raw_x5_released", int'(stall_id), 0);
    chk("raw_x5_outstanding0", int'(outstanding), 0);
    step(); idle();

    // x0 destination never tracked.
    long_op(0); id_rs1 = 0; id_rs1_used = 1;
    mid(); chk("x0_no_stall", int'(stall_id), 0);
    step(); idle();
    mid(); chk("x0_outstanding", int'(outstanding), 0);
    step();

    // Forwarding priority.
    id_valid = 1; id_rs2 = 7; id_rs2_used = 1;
    ex_mem_rd = 7; ex_mem_reg_write = 1; mem_wb_rd = 7; mem_wb_reg_write = 1;
    mid(); chk("fwd_b_exmem", int'(fwd_b_sel), 2);
    step(); ex_mem_reg_write = 0;
    mid(); chk("fwd_b_memwb", int'(fwd_b_sel), 1);
    step(); idle();

    // Outstanding limit.
    for (int i = 1; i <= 8; i++) begin
      long_op(i);
      step();
    end
    long_op(9);
    mid(); chk("full_stall", int'(stall_id), 1);
    chk("full_outstanding", int'(outstanding), 8);
    step(); retire(1);
    mid(); chk("full_same_cycle_retire", int'(stall_id), 1);
    step(); wb_valid = 0;
    mid(); chk("full_released_issue", int'(issue), 1);
    step(); idle();
    for (int i = 2; i <= 9; i++) begin
      retire(i);
      step();
    end
    idle();
    mid(); chk("full_drained", int'(outstanding), 0);

    // WAW saturation and same-cycle inc+dec.
    step();
    for (int i = 0; i < 3; i++) begin
      long_op(3);
      step();
    end
    mid(); chk("waw_stall", int'(stall_id), 1);
    step(); retire(3);
    step();
    mid(); chk("waw_inc_dec_issue", int'(issue), 1);
    step(); idle();
    mid(); chk("waw_inc_dec_net", int'(outstanding), 2);
    step(); retire(3); step(); retire(3); step(); idle();

    // Drain with two outstanding writes.
    long_op(10); step(); long_op(11); step();
    idle(); drain_req = 1; step(); drain_req = 0;
    id_valid = 1;
    mid(); chk("drain_stall", int'(stall_id), 1);
    step(); idle(); retire(10); step(); retire(11); step(); idle();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      mid(); if (drain_done) pulses++;
      step();
    end
    chk("drain_done_pulses", pulses, 1);

    // Flush mid-drain.
    long_op(12); step(); idle(); drain_req = 1; step(); drain_req = 0;
    step(); flush = 1; step(); flush = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      mid(); if (drain_done) pulses++;
      step();
    end
    chk("flush_no_pulse", pulses, 0);
    id_valid = 1; id_rs1 = 12; id_rs1_used = 1;
    mid(); chk("flush_no_stall", int'(stall_id), 0);
    chk("flush_outstanding", int'(outstanding), 0);
    step(); idle();

    // Retire to an empty counter.
    retire(9); step(); idle();
    mid(); chk("sb_err_set", int'(sb_err), 1);
    step(); step();
    mid(); chk("sb_err_sticky", int'(sb_err), 1);

    // Reset during a drain.
    step(); long_op(4); step(); idle(); drain_req = 1; step(); drain_req = 0;
    step(); rst = 1'b1; step(); step(); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      mid(); if (drain_done) pulses++;
      step();
    end
    chk("reset_drain_no_pulse", pulses, 0);
    mid(); chk("reset_drain_err_clear", int'(sb_err), 0);
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      id_valid         = ($urandom_range(9) < 7);
      ex_ready         = ($urandom_range(9) < 8);
      id_rs1           = 5'($urandom_range(11));
      id_rs2           = 5'($urandom_range(11));
      id_rs1_used      = 1'($urandom);
      id_rs2_used      = 1'($urandom);
      id_rd            = 5'($urandom_range(11));
      id_rd_we         = ($urandom_range(9) < 7);
      id_long_lat      = 1'($urandom);
      ex_mem_rd        = 5'($urandom_range(11));
      ex_mem_reg_write = 1'($urandom);
      mem_wb_rd        = 5'($urandom_range(11));
      mem_wb_reg_write = 1'($urandom);
      drain_req        = ($urandom_range(99) < 3);
      flush            = ($urandom_range(199) == 0);
      cand.delete();
      for (int r = 1; r < 12; r++) if (m_cnt[r] > 0) cand.push_back(r);
      wb_valid = ($urandom_range(9) < 4);
      if (cand.size() > 0 && $urandom_range(9) != 0)
        wb_rd = 5'(cand[$urandom_range(cand.size() - 1)]);
      else
        wb_rd = 5'($urandom_range(11));
      step();
    end
    idle();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
